// File: rtl/robot_actuator_sequencer.sv
// Turns level commands (front/turn/remove) into timed actuator pulses with busy/done status.
// Optional macro ACT_STATS_EN adds saturating completed-operation counters; otherwise they read 0.
module robot_actuator_sequencer #(
    parameter int MOVE_CYCLES   = 4,
    parameter int TURN_CYCLES   = 6,
    parameter int REMOVE_CYCLES = 3,
    parameter int TIMER_W       = 8,
    parameter int CNT_W         = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             front,
    input  logic             turn,
    input  logic             remove,
    output logic             motor_fwd,
    output logic             motor_rot,
    output logic             arm_ext,
    output logic             arm_ret,
    output logic             busy,
    output logic             done,
    output logic             conflict,
    output logic [CNT_W-1:0] moves,
    output logic [CNT_W-1:0] turns,
    output logic [CNT_W-1:0] removals
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOVE,
        S_ROTATE,
        S_EXTEND,
        S_RETRACT
    } state_e;

    // Timer holds "cycles remaining minus one", so a state lasts exactly its CYCLES count.
    localparam logic [TIMER_W-1:0] MOVE_LD   = TIMER_W'(MOVE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TURN_LD   = TIMER_W'(TURN_CYCLES - 1);
    localparam logic [TIMER_W-1:0] REMOVE_LD = TIMER_W'(REMOVE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               done_q, done_d;
    logic               conflict_q, conflict_d;
    logic [1:0]         n_cmds;

    assign n_cmds = {1'b0, front} + {1'b0, turn} + {1'b0, remove};

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        done_d     = 1'b0;
        conflict_d = conflict_q;
        case (state_q)
            S_IDLE: begin
                if (remove) begin
                    state_d = S_EXTEND;
                    timer_d = REMOVE_LD;
                end else if (turn) begin
                    state_d = S_ROTATE;
                    timer_d = TURN_LD;
                end else if (front) begin
                    state_d = S_MOVE;
                    timer_d = MOVE_LD;
                end
                if (n_cmds >= 2'd2) conflict_d = 1'b1;
            end
            S_MOVE, S_ROTATE, S_RETRACT: begin
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            S_EXTEND: begin
                // Retract follows immediately; the remove is not complete yet, so no done.
                if (timer_q != '0) begin
                    timer_d = timer_q - TIMER_W'(1);
                end else begin
                    state_d = S_RETRACT;
                    timer_d = REMOVE_LD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            done_q     <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            done_q     <= done_d;
            conflict_q <= conflict_d;
        end
    end

    assign motor_fwd = (state_q == S_MOVE);
    assign motor_rot = (state_q == S_ROTATE);
    assign arm_ext   = (state_q == S_EXTEND);
    assign arm_ret   = (state_q == S_RETRACT);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign conflict  = conflict_q;

`ifdef ACT_STATS_EN
    logic [CNT_W-1:0] moves_q, turns_q, removals_q;
    logic             fin_move, fin_turn, fin_remove;

    // Same condition that raises done_d, split per operation.
    assign fin_move   = (state_q == S_MOVE)    && (timer_q == '0);
    assign fin_turn   = (state_q == S_ROTATE)  && (timer_q == '0);
    assign fin_remove = (state_q == S_RETRACT) && (timer_q == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            moves_q    <= '0;
            turns_q    <= '0;
            removals_q <= '0;
        end else begin
            if (fin_move && (moves_q != '1))      moves_q    <= moves_q + CNT_W'(1);
            if (fin_turn && (turns_q != '1))      turns_q    <= turns_q + CNT_W'(1);
            if (fin_remove && (removals_q != '1)) removals_q <= removals_q + CNT_W'(1);
        end
    end

    assign moves    = moves_q;
    assign turns    = turns_q;
    assign removals = removals_q;
`else
    assign moves    = '0;
    assign turns    = '0;
    assign removals = '0;
`endif

endmodule
